// File: rtl/div_pkg.sv
// Shared types and constants for the seq_divider restoring divider.
// The SIGNED_DIV_EN macro enables signed mode in seq_divider and seq_divider_if.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;

   localparam int unsigned DIV_BIT_LEN = 8;
   localparam int unsigned DIV_CNT_W   = $clog2(DIV_BIT_LEN);

   // Quotient reported for a zero divisor. Users truncate it to their own width.
   localparam logic [31:0] DIV_ZERO_QUOT = '1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for seq_divider.
// The is_signed signal exists only when SIGNED_DIV_EN is defined.
interface seq_divider_if #(
   parameter int bit_len = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [bit_len-1:0] a;
   logic [bit_len-1:0] b;
`ifdef SIGNED_DIV_EN
   logic               is_signed;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [bit_len-1:0] quot;
   logic [bit_len-1:0] rem;
   logic               div_zero;
   logic               ovf;

`ifdef SIGNED_DIV_EN
   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, quot, rem, div_zero, ovf
   );
   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, quot, rem, div_zero, ovf
   );
`else
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, quot, rem, div_zero, ovf
   );
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, quot, rem, div_zero, ovf
   );
`endif
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// conditionally subtract the divisor.
module div_step #(
   parameter int bit_len = 8
) (
   input  logic [bit_len:0]   prem,
   input  logic               bit_in,
   input  logic [bit_len-1:0] divisor,
   output logic [bit_len:0]   rem_next,
   output logic               q_bit
);
   logic [bit_len:0] shifted;
   logic [bit_len:0] trial;

   // The comparison uses the full register so no partial-remainder bit is dropped
   // from the subtract decision.
   always_comb begin
      shifted  = {prem[bit_len-1:0], bit_in};
      trial    = shifted - {1'b0, divisor};
      q_bit    = ({prem, bit_in} >= {2'b00, divisor});
      rem_next = q_bit ? trial : shifted;
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SIGNED_DIV_EN to add two's-complement mode (is_signed) and overflow reporting.
module seq_divider
   import div_pkg::*;
#(
   parameter int bit_len = DIV_BIT_LEN
) (
   input logic         clk,
   input logic         rst_n,
   seq_divider_if.slave dif
);
   localparam int unsigned cnt_w = cnt_width(bit_len);
   localparam logic [bit_len-1:0] one_c = {{(bit_len-1){1'b0}}, 1'b1};
   localparam logic [bit_len-1:0] min_neg_c = {1'b1, {(bit_len-1){1'b0}}};

   div_state_t         state_reg;
   logic               in_ready_reg;
   logic               out_valid_reg;
   logic               div_zero_reg;
   logic               ovf_reg;
   logic [bit_len-1:0] quot_reg;
   logic [bit_len-1:0] rem_reg;
   logic [bit_len:0]   prem_reg;
   logic [bit_len-1:0] shift_reg;
   logic [bit_len-1:0] divisor_reg;
   logic [cnt_w-1:0]   cnt_reg;
   logic               neg_q_reg;
   logic               neg_r_reg;
   logic               ovf_pend_reg;

   logic [bit_len:0]   prem_next;
   logic               q_bit;
   logic [bit_len-1:0] shift_next;
   logic [bit_len-1:0] a_mag_next;
   logic [bit_len-1:0] b_mag_next;
   logic               neg_q_next;
   logic               neg_r_next;
   logic               ovf_next;
   logic [bit_len-1:0] quot_final;
   logic [bit_len-1:0] rem_final;

   div_step #(.bit_len(bit_len)) u_step (
      .prem     (prem_reg),
      .bit_in   (shift_reg[bit_len-1]),
      .divisor  (divisor_reg),
      .rem_next (prem_next),
      .q_bit    (q_bit)
   );

   // The dividend shifts out of the top while quotient bits fill from the bottom.
   assign shift_next = {shift_reg[bit_len-2:0], q_bit};

`ifdef SIGNED_DIV_EN
   logic a_neg;
   logic b_neg;

   always_comb begin
      a_neg      = dif.is_signed & dif.a[bit_len-1];
      b_neg      = dif.is_signed & dif.b[bit_len-1];
      a_mag_next = a_neg ? (~dif.a + one_c) : dif.a;
      b_mag_next = b_neg ? (~dif.b + one_c) : dif.b;
      neg_q_next = a_neg ^ b_neg;
      neg_r_next = a_neg;
      ovf_next   = dif.is_signed & (dif.a == min_neg_c) & (&dif.b);
      quot_final = neg_q_reg ? (~shift_next + one_c) : shift_next;
      rem_final  = neg_r_reg ? (~prem_next[bit_len-1:0] + one_c) : prem_next[bit_len-1:0];
   end
`else
   always_comb begin
      a_mag_next = dif.a;
      b_mag_next = dif.b;
      neg_q_next = 1'b0;
      neg_r_next = 1'b0;
      ovf_next   = 1'b0;
      quot_final = shift_next;
      rem_final  = prem_next[bit_len-1:0];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         div_zero_reg  <= 1'b0;
         ovf_reg       <= 1'b0;
         quot_reg      <= '0;
         rem_reg       <= '0;
         prem_reg      <= '0;
         shift_reg     <= '0;
         divisor_reg   <= '0;
         cnt_reg       <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         ovf_pend_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               in_ready_reg <= 1'b1;
               if (dif.in_valid && in_ready_reg) begin
                  in_ready_reg <= 1'b0;
                  if (dif.b == '0) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                     quot_reg      <= DIV_ZERO_QUOT[bit_len-1:0];
                     rem_reg       <= dif.a;
                     div_zero_reg  <= 1'b1;
                     ovf_reg       <= 1'b0;
                  end else begin
                     state_reg    <= CALC;
                     prem_reg     <= '0;
                     shift_reg    <= a_mag_next;
                     divisor_reg  <= b_mag_next;
                     cnt_reg      <= cnt_w'(bit_len - 1);
                     neg_q_reg    <= neg_q_next;
                     neg_r_reg    <= neg_r_next;
                     ovf_pend_reg <= ovf_next;
                  end
               end
            end
            CALC: begin
               prem_reg  <= prem_next;
               shift_reg <= shift_next;
               if (cnt_reg == '0) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
                  quot_reg      <= quot_final;
                  rem_reg       <= rem_final;
                  div_zero_reg  <= 1'b0;
                  ovf_reg       <= ovf_pend_reg;
               end else begin
                  cnt_reg <= cnt_reg - cnt_w'(1);
               end
            end
            DONE: begin
               if (dif.out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b0;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign dif.in_ready  = in_ready_reg;
   assign dif.out_valid = out_valid_reg;
   assign dif.quot      = quot_reg;
   assign dif.rem       = rem_reg;
   assign dif.div_zero  = div_zero_reg;
   assign dif.ovf       = ovf_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (bit_len = 8); signed cases run when SIGNED_DIV_EN is defined.
`timescale 1ns/1ps
module tb_seq_divider;
   localparam int BL = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seq_divider_if #(.bit_len(BL)) dif ();
   seq_divider #(.bit_len(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dif   (dif)
   );

   typedef struct {
      logic [7:0] quot;
      logic [7:0] rem;
      logic       dz;
      logic       ovf;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference results from plain integer arithmetic; signed division truncates toward zero.
   function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic sg);
      exp_t e;
      int   sa;
      int   sb;
      e.dz  = (bv == 8'd0);
      e.ovf = 1'b0;
      e.lat = (bv == 8'd0) ? 1 : BL + 1;
      if (bv == 8'd0) begin
         e.quot = 8'hFF;
         e.rem  = av;
      end else if (!sg) begin
         e.quot = av / bv;
         e.rem  = av % bv;
      end else begin
         sa = $signed(av);
         sb = $signed(bv);
         if (sa == -128 && sb == -1) begin
            e.quot = 8'h80;
            e.rem  = 8'h00;
            e.ovf  = 1'b1;
         end else begin
            e.quot = 8'(sa / sb);
            e.rem  = 8'(sa % sb);
         end
      end
      return e;
   endfunction

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sg, input int hold);
      exp_t e;
      int   lat;
      sb_q.push_back(model(av, bv, sg));
      @(negedge clk);
      check_val("in_ready_idle", dif.in_ready, 1);
      dif.in_valid = 1'b1;
      dif.a        = av;
      dif.b        = bv;
`ifdef SIGNED_DIV_EN
      dif.is_signed = sg;
`endif
      dif.out_ready = (hold == 0);
      @(negedge clk);
      // Keep offering different operands while busy; they must be ignored.
      dif.a = ~av;
      dif.b = bv + 8'd1;
`ifdef SIGNED_DIV_EN
      dif.is_signed = ~sg;
`endif
      check_val("in_ready_busy", dif.in_ready, 0);
      lat = 1;
      while (!dif.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      dif.in_valid = 1'b0;
      check_val("out_valid_arrival", dif.out_valid, 1);
      e = sb_q.pop_front();
      check_val("latency", lat, e.lat);
      check_val("quot", dif.quot, e.quot);
      check_val("rem", dif.rem, e.rem);
      check_val("div_zero", dif.div_zero, e.dz);
      check_val("ovf", dif.ovf, e.ovf);
      $display("op a=%02h b=%02h s=%0b -> quot=%02h rem=%02h dz=%0b ovf=%0b lat=%0d",
               av, bv, sg, dif.quot, dif.rem, dif.div_zero, dif.ovf, lat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("hold_valid", dif.out_valid, 1);
         check_val("hold_quot", dif.quot, e.quot);
         check_val("hold_rem", dif.rem, e.rem);
         check_val("hold_in_ready", dif.in_ready, 0);
      end
      dif.out_ready = 1'b1;
      @(negedge clk);
      check_val("post_out_valid", dif.out_valid, 0);
      check_val("post_in_ready", dif.in_ready, 1);
   endtask

   initial begin
      logic [7:0] av;
      logic [7:0] bv;
      rst_n         = 1'b0;
      dif.in_valid  = 1'b0;
      dif.a         = '0;
      dif.b         = '0;
      dif.out_ready = 1'b1;
`ifdef SIGNED_DIV_EN
      dif.is_signed = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_val("rst_in_ready", dif.in_ready, 0);
      check_val("rst_out_valid", dif.out_valid, 0);
      check_val("rst_quot", dif.quot, 0);
      check_val("rst_rem", dif.rem, 0);
      check_val("rst_div_zero", dif.div_zero, 0);
      check_val("rst_ovf", dif.ovf, 0);
      rst_n = 1'b1;

      run_op(8'd100, 8'd7, 1'b0, 0);
      run_op(8'd5, 8'd0, 1'b0, 0);
      run_op(8'd255, 8'd1, 1'b0, 5);

      // Abandon an operation with an asynchronous reset mid-calculation.
      @(negedge clk);
      dif.in_valid = 1'b1;
      dif.a        = 8'd200;
      dif.b        = 8'd3;
      @(negedge clk);
      dif.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_out_valid", dif.out_valid, 0);
      check_val("abort_in_ready", dif.in_ready, 0);
      check_val("abort_quot", dif.quot, 0);
      check_val("abort_rem", dif.rem, 0);
      check_val("abort_div_zero", dif.div_zero, 0);
      check_val("abort_ovf", dif.ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'd9, 8'd4, 1'b0, 0);

`ifdef SIGNED_DIV_EN
      run_op(8'hF9, 8'h02, 1'b1, 0);
      run_op(8'h80, 8'hFF, 1'b1, 0);
      run_op(8'h85, 8'h00, 1'b1, 0);
      for (int i = 0; i < 6; i++) begin
         av = 8'($urandom_range(0, 255));
         bv = 8'($urandom_range(1, 255));
         run_op(av, bv, 1'b1, i % 2);
      end
`endif

      for (int i = 0; i < 10; i++) begin
         av = 8'($urandom_range(0, 255));
         bv = (i % 4 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
         run_op(av, bv, 1'b0, i % 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
